// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises up to four requesters' 1..4-byte packets
// onto a single UART transmitter, MSB byte first, with a tx_busy handshake timeout.
module uart_tx_arbiter #(
    parameter int HI_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [7:0]   req_len,
    input  logic [127:0] req_data,
    output logic [3:0]   ack,
    output logic         busy,
    output logic [1:0]   active_id,
    output logic         err,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_busy
);
    localparam int TW = $clog2(HI_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t        state;
    logic [1:0]    last_grant;
    logic [1:0]    byte_idx;
    logic [1:0]    grant_id;
    logic [31:0]   data_q;
    logic [TW-1:0] hi_cnt;
    logic          found;

    // Search upward from last_grant+1; last_grant itself is checked last.
    always_comb begin
        grant_id = last_grant;
        found    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[2'(last_grant + 2'(i))]) begin
                found    = 1'b1;
                grant_id = 2'(last_grant + 2'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            ack        <= 4'b0000;
            busy       <= 1'b0;
            active_id  <= 2'd0;
            err        <= 1'b0;
            last_grant <= 2'd3;
            byte_idx   <= 2'd0;
            data_q     <= 32'd0;
            hi_cnt     <= '0;
        end else begin
            tx_start <= 1'b0;
            ack      <= 4'b0000;
            case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        active_id <= grant_id;
                        busy      <= 1'b1;
                        byte_idx  <= req_len[{grant_id, 1'b0} +: 2];
                        data_q    <= req_data[{grant_id, 5'b00000} +: 32];
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= data_q[{byte_idx, 3'b000} +: 8];
                        hi_cnt   <= '0;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (hi_cnt == TW'(HI_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: flag it and resend the same byte.
                        err   <= 1'b1;
                        state <= LOAD;
                    end else begin
                        hi_cnt <= hi_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_idx == 2'd0) begin
                            ack   <= 4'b0001 << active_id;
                            state <= DONE;
                        end else begin
                            byte_idx <= byte_idx - 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    last_grant <= active_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected packets,
// a negedge monitor checks every launch, grant and ack against them.
module tb_uart_tx_arbiter;
    localparam int HI_TO = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [7:0]   req_len = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   ack;
    logic         busy;
    logic [1:0]   active_id;
    logic         err;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;

    uart_tx_arbiter #(.HI_TIMEOUT(HI_TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
        .ack(ack), .busy(busy), .active_id(active_id), .err(err),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int uart_len = 3;
    int ucnt;
    bit bp_force = 0;
    bit bp_mode = 0;
    bit drop_this = 0;
    int ign_req = 0;
    int ign_done = 0;

    // UART model: busy for uart_len cycles starting the cycle after an accepted launch.
    always @(posedge clk or posedge rst) begin
        if (rst) ucnt <= 0;
        else if (tx_start && !drop_this) ucnt <= uart_len;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign tx_busy = (ucnt != 0) || bp_force;

    logic [7:0] exp_bytes[$];
    int         exp_ack[$];
    logic [7:0] tx_log[$];
    int         grant_log[$];
    int         ack_cnt = 0;
    int         m_last = 3;
    bit         m_err = 0;
    bit         in_svc = 0;
    int         cur_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    function automatic logic [31:0] log_word();
        logic [31:0] w = 0;
        foreach (tx_log[k]) w = {w[23:0], tx_log[k]};
        return w;
    endfunction

    function automatic logic [31:0] grants_word(input int n);
        logic [31:0] w = 0;
        for (int k = 0; k < n && k < grant_log.size(); k++) w = {w[29:0], 2'(grant_log[k])};
        return w;
    endfunction

    // Monitor / scoreboard
    initial begin
        int cyc = 0, g_cyc = 0, ign_cyc = 0, w, id;
        bit busy_p = 0, start_p = 0, err_p = 0, first_start = 0, ign_pending = 0;
        logic [3:0] ack_p = 0, req_s = 0, e;
        logic [7:0] len_s = 0;
        logic [127:0] data_s = 0;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_outputs", {15'd0, tx_start, tx_data, ack, busy, active_id, err}, 0);
                exp_bytes.delete(); exp_ack.delete();
                m_last = 3; m_err = 0; in_svc = 0; ign_pending = 0; ign_done = ign_req;
                busy_p = 0; start_p = 0; err_p = 0; ack_p = 0;
            end else begin
                if (busy && !busy_p) begin
                    chk("grant_had_req", 32'(req_s != 0), 1);
                    w = rr_pick(req_s, m_last);
                    if (w < 0) w = 0;
                    chk("grant_id", active_id, w);
                    grant_log.push_back(w);
                    d = data_s[32*w +: 32];
                    for (int k = int'(len_s[2*w +: 2]); k >= 0; k--) exp_bytes.push_back(d[8*k +: 8]);
                    exp_ack.push_back(w);
                    in_svc = 1; cur_id = w; g_cyc = cyc; first_start = 1;
                end
                if (tx_start) begin
                    tx_log.push_back(tx_data);
                    chk("start_while_busy", busy, 1);
                    chk("tx_start_gap", start_p, 0);
                    if (exp_bytes.size() == 0) chk("tx_unexpected", 1, 0);
                    else begin
                        chk("tx_data", tx_data, exp_bytes[0]);
                        if (ign_pending) begin chk("reissue_delay", cyc - ign_cyc, HI_TO + 1); ign_pending = 0; end
                        if (first_start && !bp_mode) chk("first_latency", cyc - g_cyc, 1);
                        first_start = 0;
                        if (ign_req != ign_done) begin
                            ign_done++; drop_this = 1; ign_pending = 1; ign_cyc = cyc; m_err = 1;
                        end else begin
                            drop_this = 0; void'(exp_bytes.pop_front());
                        end
                    end
                end
                if (err && !err_p) chk("err_delay", cyc - ign_cyc, HI_TO);
                if (err_p) chk("err_sticky", err, 1);
                if (ack != 0) begin
                    id = (exp_ack.size() != 0) ? exp_ack.pop_front() : -1;
                    e = (id >= 0) ? 4'(1 << id) : 4'b0;
                    chk("ack_onehot", ack, e);
                    chk("ack_bytes_left", exp_bytes.size(), 0);
                    chk("busy_at_ack", busy, 1);
                    chk("err_at_ack", err, m_err);
                    if (id >= 0) m_last = id;
                    in_svc = 0; ack_cnt++;
                end
                if (ack_p != 0) begin
                    chk("ack_width", ack, 0);
                    chk("busy_after_ack", busy, 0);
                end
                busy_p = busy; start_p = tx_start; err_p = err; ack_p = ack;
            end
            req_s = req; len_s = req_len; data_s = req_data;
        end
    end

    task automatic do_reset();
        rst = 1; req = '0; req_len = '0; req_data = '0; bp_force = 0; bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        tx_log.delete(); grant_log.delete(); ack_cnt = 0;
        rst = 0;
    endtask

    task automatic wait_acks(input int n, input int limit, input bit drop, output logic [3:0] last);
        int got = 0;
        last = '0;
        for (int t = 0; t < limit && got < n; t++) begin
            @(posedge clk); #1;
            if (ack != 0) begin
                got++; last = ack;
                if (drop) req = req & ~ack;
            end
        end
        chk("ack_wait", got, n);
    endtask

    task automatic set_req(input int i);
        req[i] = 1'b1;
        req_len[2*i +: 2] = 2'($urandom_range(0, 3));
        req_data[32*i +: 32] = $urandom;
    endtask

    task automatic run_random(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            uart_len = $urandom_range(1, 6);
            if (ign_req == ign_done && $urandom_range(0, 150) == 0) ign_req++;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 1) == 1) set_req(i);
                    else req[i] = 1'b0;
                end else if (in_svc && cur_id == i) begin
                    if ($urandom_range(0, 40) == 0) begin
                        req[i] = 1'b0; req_data[32*i +: 32] = $urandom;
                        req_len[2*i +: 2] = 2'($urandom_range(0, 3));
                    end
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    set_req(i);
                end
            end
        end
    endtask

    initial begin
        logic [3:0] a;
        int t;
        do_reset();
        chk("reset_state", {15'd0, tx_start, tx_data, ack, busy, active_id, err}, 0);

        // Single 3-byte packet, MSB first
        uart_len = 10;
        req_len[1:0] = 2'd2; req_data[31:0] = 32'h00A1B2C3; req[0] = 1;
        wait_acks(1, 300, 1, a);
        repeat (5) @(posedge clk);
        #1;
        chk("single_count", tx_log.size(), 3);
        chk("single_bytes", log_word(), 32'h00A1B2C3);
        chk("single_ack", a, 4'b0001);
        chk("single_ack_cnt", ack_cnt, 1);
        chk("single_busy_low", busy, 0);

        // Contention: all held high, one-byte packets
        do_reset();
        uart_len = 3; req_data = {$urandom, $urandom, $urandom, $urandom}; req = 4'hF;
        wait_acks(5, 500, 0, a);
        req = 4'h0;
        chk("rr_order", grants_word(5), {22'd0, 10'b00_01_10_11_00});

        // Timeout: first launch ignored, byte resent
        do_reset();
        uart_len = 4; ign_req++;
        req_len[7:6] = 2'd1; req_data[127:96] = 32'h00005A3C; req[3] = 1;
        wait_acks(1, 400, 1, a);
        chk("timeout_count", tx_log.size(), 3);
        chk("timeout_bytes", log_word(), 32'h005A5A3C);
        chk("timeout_err", err, 1);
        chk("timeout_ack", a, 4'b1000);

        // Back-pressure at grant
        do_reset();
        bp_mode = 1; bp_force = 1; uart_len = 3;
        req_data[95:64] = 32'h00000077; req[2] = 1;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_no_start", tx_log.size(), 0);
        chk("bp_busy", busy, 1);
        bp_force = 0;
        wait_acks(1, 200, 1, a);
        chk("bp_one_start", tx_log.size(), 1);
        chk("bp_byte", log_word(), 32'h77);
        bp_mode = 0;

        // Reset during the second of four bytes
        do_reset();
        uart_len = 4;
        req_len[3:2] = 2'd3; req_data[63:32] = 32'h11223344; req[1] = 1;
        for (t = 0; t < 400 && tx_log.size() < 2; t++) @(posedge clk);
        chk("second_byte_seen", 32'(tx_log.size() >= 2), 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("async_rst", {15'd0, tx_start, tx_data, ack, busy, active_id, err}, 0);
        repeat (2) @(posedge clk);
        #1;
        req = '0; req_len = '0; req_data = '0;
        tx_log.delete(); grant_log.delete();
        rst = 0;
        chk("rst_no_ack", ack_cnt, 0);
        req_len[5:4] = 2'd1; req_data[95:64] = 32'h0000BEEF; req[2] = 1;
        wait_acks(1, 300, 1, a);
        chk("post_rst_grant", grants_word(1), 2);
        chk("post_rst_bytes", log_word(), 32'h0000BEEF);
        chk("post_rst_ack", a, 4'b0100);

        // Requester drops req mid-packet
        do_reset();
        uart_len = 2;
        req_len[3:2] = 2'd3; req_data[63:32] = 32'hDEADBEEF; req[1] = 1;
        for (t = 0; t < 20 && !busy; t++) begin @(posedge clk); #1; end
        chk("drop_granted", busy, 1);
        req[1] = 0; req_data[63:32] = 32'h0; req_len[3:2] = 2'd0;
        wait_acks(1, 400, 0, a);
        chk("drop_count", tx_log.size(), 4);
        chk("drop_bytes", log_word(), 32'hDEADBEEF);
        chk("drop_ack", a, 4'b0010);

        // Randomized traffic, then drain
        do_reset();
        run_random(4000);
        for (t = 0; t < 3000 && (req != 0 || busy); t++) begin
            @(posedge clk); #1;
            req = req & ~ack;
        end
        chk("drain_idle", {30'd0, req != 0, busy}, 0);
        chk("drain_acks", exp_ack.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter HI_TIMEOUT, default 15: clock cycles to wait for tx_busy to rise after a tx_start pulse.
REQ-002 clk  input  1  clock; all logic SHALL be rising-edge triggered.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester packet request; bit i belongs to requester i.
REQ-005 req_len  input  8  2 bits per requester at [2i+1:2i]; value n means n+1 bytes (1..4).
REQ-006 req_data  input  128  32 bits per requester at [32i+31:32i].
REQ-007 ack  output  4  one-cycle, one-hot completion pulse to the served requester.
REQ-008 busy  output  1  high from grant until the ack cycle, inclusive.
REQ-009 active_id  output  2  index of the requester being served; holds its last value when idle.
REQ-010 err  output  1  sticky; set on any timeout; cleared only by rst.
REQ-011 tx_start  output  1  one-cycle byte launch strobe to the UART transmitter.
REQ-012 tx_data  output  8  byte presented with tx_start; held stable until the next launch.
REQ-013 tx_busy  input  1  UART transmitter busy; rises the cycle after an accepted tx_start and falls after the stop bit.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, WAIT_HI, WAIT_LO and DONE.
REQ-015 IDLE: if req is nonzero, grant the first set bit searching upward from (last_grant+1) mod 4; latch req_len and req_data of the winner, set busy and active_id, and go to LOAD; otherwise stay in IDLE.
REQ-016 Bytes SHALL be sent MSB-first: for length n, send data[8n+7:8n] first and data[7:0] last.
REQ-017 LOAD: when tx_busy=0, assert tx_start for exactly one cycle with the current byte on tx_data and go to WAIT_HI; when tx_busy=1, wait in LOAD with tx_start=0.
REQ-018 WAIT_HI: on tx_busy=1 go to WAIT_LO; if tx_busy stays low for HI_TIMEOUT cycles, set err and return to LOAD to reissue the same byte.
REQ-019 WAIT_LO: on tx_busy=0, go to DONE if the byte just sent was the last byte; otherwise advance to the next byte and go to LOAD.
REQ-020 DONE: pulse ack[active_id] for one cycle, set last_grant=active_id, clear busy, and go to IDLE.
REQ-021 Latency from req seen in IDLE to the first tx_start SHALL be 2 cycles when tx_busy=0.
REQ-022 Requesters SHALL hold req, req_len and req_data until ack; the block SHALL ignore changes to these after the grant, including req deasserting mid-packet, and SHALL complete the latched packet.
REQ-023 A requester with req still high in the cycle after ack SHALL be arbitrated normally and SHALL lose to any other pending requester.
REQ-024 tx_start SHALL never be asserted outside LOAD and never in two consecutive cycles.

Reset
REQ-025 While rst=1: state IDLE, tx_start=0, tx_data=8'h00, ack=0, busy=0, active_id=0, err=0, last_grant=3 (requester 0 has first priority), byte counter=0.
REQ-026 Reset mid-packet SHALL abort immediately with no ack; the packet is lost, and the first grant after release follows REQ-025 priority.

Verification
REQ-027 Single request: req=4'b0001, len=2'd2, data[31:0]=32'h00A1B2C3, UART model busy 10 cycles per byte -> tx_data sequence A1, B2, C3; ack=4'b0001 once; busy low afterwards.
REQ-028 Contention: req=4'b1111 held and re-raised after each ack, all len=0 -> grant order 0,1,2,3,0; each ack is one-hot and one cycle wide.
REQ-029 Timeout: UART model ignores the first tx_start -> err=1 after 15 cycles; the same byte is reissued; the packet completes with ack.
REQ-030 Back-pressure: tx_busy=1 when the grant occurs -> no tx_start until tx_busy=0, then one tx_start only.
REQ-031 Reset mid-packet: assert rst during the 2nd of 4 bytes -> all outputs return to their reset values at once, no ack; a new request from requester 2 is served normally afterwards.
REQ-032 req drop: requester 1 deasserts req after its grant with len=3 -> all 4 bytes are still sent and ack[1] still pulses.
